// File: rtl/nios2e_cpu_ocimem_arbiter.sv
// nios2e_cpu_ocimem_arbiter: round-robin sharing of the OCI RAM between JTAG strobes and the Avalon debug slave.
// Optional OCIMEM_AUTOINC_EN: JTAG address post-increments on every completed JTAG access.
module nios2e_cpu_ocimem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [37:0]       jdo,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);
   typedef enum logic [1:0] {IDLE, G_JTAG, G_AVS, RD_WAIT} state_t;
   state_t state, state_nxt;
   logic jtag_pend, jtag_wr, last_avs, cur_avs, cur_wr;
   logic [31:0] jtag_wdata;
   logic [ADDR_W-1:0] jtag_addr, b_addr;
   logic avs_req, grant_j, grant_a, in_grant, done, avs_ack, b_bad;
   logic unused_jdo;

   assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
   assign avs_req = avs_read | avs_write;
   assign in_grant = (state == G_JTAG) || (state == G_AVS);
   assign done = (in_grant & cur_wr) | (state == RD_WAIT);
   assign avs_ack = done & cur_avs;
   assign ram_wr = in_grant & cur_wr;
   assign ram_wdata = cur_avs ? avs_writedata : jtag_wdata;
   assign avs_readdata = (avs_ack & ~cur_wr) ? ram_rdata : '0;
   assign avs_waitrequest = avs_req & ~avs_ack & ~reset;
   // an address strobe in the same cycle as the access strobe takes effect first
   assign b_addr = take_action_ocimem_a ? jdo[17 +: ADDR_W] : jtag_addr;
   assign b_bad = 32'(b_addr) >= DEPTH;

   always_comb begin
      grant_j = (state == IDLE) && jtag_pend && (!avs_req || last_avs);
      grant_a = (state == IDLE) && avs_req && !grant_j;
      state_nxt = grant_j ? G_JTAG : grant_a ? G_AVS : (in_grant && !cur_wr) ? RD_WAIT : IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         jtag_pend     <= 1'b0;
         jtag_wr       <= 1'b0;
         jtag_wdata    <= '0;
         jtag_addr     <= '0;
         last_avs      <= 1'b1;
         cur_avs       <= 1'b0;
         cur_wr        <= 1'b0;
         ram_addr      <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_j | grant_a) begin
            last_avs <= grant_a;
            cur_avs  <= grant_a;
            cur_wr   <= grant_j ? jtag_wr : (avs_write & ~avs_read);
            ram_addr <= grant_j ? jtag_addr : avs_address;
         end
         if (done & ~cur_avs) begin
            jtag_pend     <= 1'b0;
            monitor_ready <= 1'b1;
            if (!cur_wr) MonDReg <= ram_rdata;
`ifdef OCIMEM_AUTOINC_EN
            jtag_addr <= jtag_addr + 1'b1;
`else
            jtag_addr <= jtag_addr;
`endif
         end
         if (take_action_ocimem_a) jtag_addr <= jdo[17 +: ADDR_W];
         if (take_action_ocimem_b) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b1;
            if (!jtag_pend && !b_bad) begin
               monitor_error <= 1'b0;
               jtag_pend     <= 1'b1;
               jtag_wr       <= jdo[35];
               jtag_wdata    <= jdo[34:3];
            end
         end
      end
   end
endmodule
